// File: rtl/balance_ledger.sv
// Serialising ATM account ledger: USD plus four coin balances, one request at a time.
// Each request walks IDLE -> CALC -> CHECK -> COMMIT and commits atomically or not at all.
module balance_ledger #(
  parameter int unsigned INIT_DOLLARS = 1000,
  parameter int unsigned MAX_BAL      = 99_999_999,
  parameter int          PRICE_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [1:0]         req_coin,
  input  logic [31:0]        req_amount,
  input  logic [PRICE_W-1:0] price_btc,
  input  logic [PRICE_W-1:0] price_eth,
  input  logic [PRICE_W-1:0] price_xrp,
  input  logic [PRICE_W-1:0] price_ltc,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [31:0]        balance_dollars_out,
  output logic [31:0]        balance_btc,
  output logic [31:0]        balance_eth,
  output logic [31:0]        balance_xrp,
  output logic [31:0]        balance_ltc
);

  localparam int CW  = 32 + PRICE_W;
  localparam int CW1 = CW + 1;

  localparam logic [1:0] OP_DEP  = 2'b00;
  localparam logic [1:0] OP_WDR  = 2'b01;
  localparam logic [1:0] OP_BUY  = 2'b10;
  localparam logic [1:0] OP_SELL = 2'b11;

  localparam logic [1:0] EC_OK    = 2'b00;
  localparam logic [1:0] EC_INSUF = 2'b01;
  localparam logic [1:0] EC_OVFL  = 2'b10;
  localparam logic [1:0] EC_ZERO  = 2'b11;

  localparam logic [32:0]   MAX33 = 33'(MAX_BAL);
  localparam logic [CW:0]   MAXC  = CW1'(MAX_BAL);

  typedef enum logic [1:0] {IDLE, CALC, CHECK, COMMIT} state_t;

  state_t               state_reg;
  logic [1:0]           op_reg;
  logic [1:0]           coin_reg;
  logic [31:0]          amount_reg;
  logic [PRICE_W-1:0]   price_reg;
  logic [CW-1:0]        cost_reg;
  logic [1:0]           verdict_reg;
  logic [31:0]          new_usd_reg;
  logic [31:0]          new_coin_reg;
  logic                 ready_reg;
  logic                 done_reg;
  logic                 err_reg;
  logic [1:0]           err_code_reg;
  logic [31:0]          usd_reg;
  logic [31:0]          coin_bal_reg [4];

  logic [PRICE_W-1:0]   price_sel;
  logic [CW-1:0]        cost_next;
  logic [31:0]          coin_cur;
  logic [32:0]          usd_plus_amt;
  logic [32:0]          coin_plus_amt;
  logic [CW:0]          usd_plus_cost;
  logic [1:0]           verdict_next;
  logic [31:0]          new_usd_next;
  logic [31:0]          new_coin_next;

  always_comb begin
    price_sel = price_btc;
    case (req_coin)
      2'd0: price_sel = price_btc;
      2'd1: price_sel = price_eth;
      2'd2: price_sel = price_xrp;
      2'd3: price_sel = price_ltc;
      default: price_sel = price_btc;
    endcase
  end

  assign cost_next     = CW'(amount_reg) * CW'(price_reg);
  assign coin_cur      = coin_bal_reg[coin_reg];
  assign usd_plus_amt  = {1'b0, usd_reg} + {1'b0, amount_reg};
  assign coin_plus_amt = {1'b0, coin_cur} + {1'b0, amount_reg};
  assign usd_plus_cost = CW1'(usd_reg) + {1'b0, cost_reg};

  // All sums are one bit wider than their operands, so range checks never see a wrapped value.
  always_comb begin
    verdict_next  = EC_OK;
    new_usd_next  = usd_reg;
    new_coin_next = coin_cur;
    case (op_reg)
      OP_DEP: begin
        if (usd_plus_amt > MAX33) verdict_next = EC_OVFL;
        else                      new_usd_next = usd_plus_amt[31:0];
      end
      OP_WDR: begin
        if (amount_reg > usd_reg) verdict_next = EC_INSUF;
        else                      new_usd_next = usd_reg - amount_reg;
      end
      OP_BUY: begin
        if (cost_reg > CW'(usd_reg)) begin
          verdict_next = EC_INSUF;
        end else if (coin_plus_amt > MAX33) begin
          verdict_next = EC_OVFL;
        end else begin
          new_usd_next  = usd_reg - cost_reg[31:0];
          new_coin_next = coin_plus_amt[31:0];
        end
      end
      OP_SELL: begin
        if (amount_reg > coin_cur) begin
          verdict_next = EC_INSUF;
        end else if (usd_plus_cost > MAXC) begin
          verdict_next = EC_OVFL;
        end else begin
          new_usd_next  = usd_plus_cost[31:0];
          new_coin_next = coin_cur - amount_reg;
        end
      end
      default: verdict_next = EC_OK;
    endcase
    if (amount_reg == 32'd0) verdict_next = EC_ZERO;
  end

  // Ready is registered so it stays low through the done cycle and rises one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= 2'b00;
      coin_reg     <= 2'b00;
      amount_reg   <= 32'd0;
      price_reg    <= '0;
      cost_reg     <= '0;
      verdict_reg  <= EC_OK;
      new_usd_reg  <= 32'd0;
      new_coin_reg <= 32'd0;
      ready_reg    <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= EC_OK;
      usd_reg      <= 32'(INIT_DOLLARS);
      for (int i = 0; i < 4; i++) coin_bal_reg[i] <= 32'd0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (done_reg) ready_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (req_valid && ready_reg) begin
            op_reg     <= req_op;
            coin_reg   <= req_coin;
            amount_reg <= req_amount;
            price_reg  <= price_sel;
            ready_reg  <= 1'b0;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          cost_reg  <= cost_next;
          state_reg <= CHECK;
        end
        CHECK: begin
          verdict_reg  <= verdict_next;
          new_usd_reg  <= new_usd_next;
          new_coin_reg <= new_coin_next;
          state_reg    <= COMMIT;
        end
        COMMIT: begin
          done_reg     <= 1'b1;
          err_reg      <= (verdict_reg != EC_OK);
          err_code_reg <= verdict_reg;
          if (verdict_reg == EC_OK) begin
            usd_reg                <= new_usd_reg;
            coin_bal_reg[coin_reg] <= new_coin_reg;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready           = ready_reg;
  assign done                = done_reg;
  assign err                 = err_reg;
  assign err_code            = err_code_reg;
  assign balance_dollars_out = usd_reg;
  assign balance_btc         = coin_bal_reg[0];
  assign balance_eth         = coin_bal_reg[1];
  assign balance_xrp         = coin_bal_reg[2];
  assign balance_ltc         = coin_bal_reg[3];

endmodule
